// File: rtl/nwd_pkg.sv
// Shared types and constants for the round-robin GCD job arbiter.
package nwd_pkg;

    localparam int DATA_W        = 8;
    localparam int N_REQ_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    // The engine never terminates on a zero operand, so such jobs are
    // answered locally: gcd(x,0) = x and gcd(0,0) = 0, both equal to a|b.
    function automatic logic [DATA_W-1:0] zero_bypass(input logic [DATA_W-1:0] a,
                                                      input logic [DATA_W-1:0] b);
        return a | b;
    endfunction

    function automatic logic is_zero_job(input logic [DATA_W-1:0] a,
                                         input logic [DATA_W-1:0] b);
        return (a == '0) || (b == '0);
    endfunction

endpackage

// File: rtl/nwd_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after rr_ptr,
// searching circularly.
module rr_picker
    import nwd_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEFAULT,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    // Scan offsets from the far end down so the nearest hit to rr_ptr wins.
    always_comb begin
        int cand;
        valid = 1'b0;
        idx   = '0;
        cand  = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = (int'(rr_ptr) + k) % N_REQ;
            if (req[cand]) begin
                valid = 1'b1;
                idx   = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/nwd_arbiter.sv
// Round-robin arbiter/sequencer sharing one GCD engine between N_REQ
// requesters. Zero-operand jobs are resolved without touching the engine.
module nwd_arbiter
    import nwd_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEFAULT,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic                      clk,
    input  logic                      nrst,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*DATA_W-1:0]   opa,
    input  logic [N_REQ*DATA_W-1:0]   opb,
    output logic [N_REQ-1:0]          done,
    output logic [DATA_W-1:0]         res,
    output logic                      busy,
    output logic [IDX_W-1:0]          gnt_idx,
    output logic                      eng_start,
    output logic [DATA_W-1:0]         eng_ina,
    output logic [DATA_W-1:0]         eng_inb,
    input  logic                      eng_ready,
    input  logic [DATA_W-1:0]         eng_out
);

    state_t             state;
    state_t             state_nxt;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   ptr_next;
    logic [DATA_W-1:0]  op_a;
    logic [DATA_W-1:0]  op_b;

    logic               pick_valid;
    logic [IDX_W-1:0]   pick_idx;
    logic [DATA_W-1:0]  pick_a;
    logic [DATA_W-1:0]  pick_b;
    logic               zero_job;

    logic [DATA_W-1:0]  opa_arr [N_REQ];
    logic [DATA_W-1:0]  opb_arr [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_ops
        assign opa_arr[i] = opa[i*DATA_W +: DATA_W];
        assign opb_arr[i] = opb[i*DATA_W +: DATA_W];
    end

    rr_picker #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .req    (req),
        .rr_ptr (rr_ptr),
        .valid  (pick_valid),
        .idx    (pick_idx)
    );

    assign pick_a   = opa_arr[pick_idx];
    assign pick_b   = opb_arr[pick_idx];
    assign zero_job = is_zero_job(pick_a, pick_b);
    assign ptr_next = (gnt_idx == IDX_W'(N_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);

    // Engine operands come straight from the job latches in every state.
    assign eng_ina  = op_a;
    assign eng_inb  = op_b;

    // State register.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; IDLE waits for a free engine unless the job bypasses it.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (pick_valid) begin
                    if (zero_job) begin
                        state_nxt = RESP;
                    end else if (eng_ready) begin
                        state_nxt = LAUNCH;
                    end
                end
            end
            LAUNCH:  state_nxt = WAIT;
            WAIT:    if (eng_ready) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Job latches, result register and round-robin pointer.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            rr_ptr  <= '0;
            gnt_idx <= '0;
            op_a    <= '0;
            op_b    <= '0;
            res     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pick_valid) begin
                        gnt_idx <= pick_idx;
                        op_a    <= pick_a;
                        op_b    <= pick_b;
                        if (zero_job) begin
                            res <= zero_bypass(pick_a, pick_b);
                        end
                    end
                end
                WAIT: begin
                    if (eng_ready) begin
                        res <= eng_out;
                    end
                end
                RESP: begin
                    rr_ptr <= ptr_next;
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs decoded purely from registered state and grant index.
    always_comb begin
        done          = '0;
        done[gnt_idx] = (state == RESP);
        busy          = (state != IDLE);
        eng_start     = (state == LAUNCH);
    end

endmodule

// File: tb/tb_nwd_arbiter.sv
// Bench for nwd_arbiter with a subtractive GCD engine stub and an in-order
// scoreboard of expected (requester, result) pairs.
module tb_nwd_arbiter;

    localparam int N  = 4;
    localparam int IW = 2;

    logic            clk;
    logic            nrst;
    logic [N-1:0]    req;
    logic [N*8-1:0]  opa;
    logic [N*8-1:0]  opb;
    logic [N-1:0]    done;
    logic [7:0]      res;
    logic            busy;
    logic [IW-1:0]   gnt_idx;
    logic            eng_start;
    logic [7:0]      eng_ina;
    logic [7:0]      eng_inb;
    logic            eng_ready;
    logic [7:0]      eng_out;

    nwd_arbiter #(.N_REQ(N), .IDX_W(IW)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .req       (req),
        .opa       (opa),
        .opb       (opb),
        .done      (done),
        .res       (res),
        .busy      (busy),
        .gnt_idx   (gnt_idx),
        .eng_start (eng_start),
        .eng_ina   (eng_ina),
        .eng_inb   (eng_inb),
        .eng_ready (eng_ready),
        .eng_out   (eng_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Engine stub: subtractive GCD, one step per cycle, ready high when idle.
    logic [7:0] ea, eb, eo;
    logic       erdy;
    logic       hold;

    always @(posedge clk) begin
        if (!nrst) begin
            erdy <= 1'b1;
            ea   <= 8'd0;
            eb   <= 8'd0;
            eo   <= 8'd0;
        end else if (eng_start) begin
            ea   <= eng_ina;
            eb   <= eng_inb;
            erdy <= 1'b0;
        end else if (!erdy) begin
            if (ea == eb) begin
                eo   <= ea;
                erdy <= 1'b1;
            end else if (ea > eb) begin
                ea <= ea - eb;
            end else begin
                eb <= eb - ea;
            end
        end
    end

    assign eng_ready = erdy & ~hold;
    assign eng_out   = eo;

    typedef struct {
        int         idx;
        logic [7:0] res;
    } exp_t;

    exp_t         sb [$];
    int           checks;
    int           errors;
    int           cyc;
    int           starts;
    int           last_cyc;
    logic [N-1:0] seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        if (obs !== want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, want);
        end
    endtask

    function automatic int idx_of(input logic [N-1:0] v);
        int r = -1;
        for (int i = 0; i < N; i++) begin
            if (v[i]) r = i;
        end
        return r;
    endfunction

    // Advance one clock and observe outputs on the falling edge.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (eng_start) starts++;
        if (done != '0) begin
            chk("done_onehot", $countones(done), 1);
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'(done), 0);
            end else begin
                e = sb.pop_front();
                chk("done_idx", idx_of(done), e.idx);
                chk("res", 32'(res), 32'(e.res));
            end
            seen     = seen | done;
            last_cyc = cyc;
            req      = req & ~done;
        end
    endtask

    task automatic wait_mask(input logic [N-1:0] mask, input int budget);
        int n = 0;
        while (((seen & mask) != mask) && (n < budget)) begin
            tick();
            n++;
        end
        if ((seen & mask) != mask) chk("timeout", 32'(seen & mask), 32'(mask));
    endtask

    task automatic set_job(input int i, input logic [7:0] a, input logic [7:0] b);
        opa[i*8 +: 8] = a;
        opb[i*8 +: 8] = b;
        req[i]        = 1'b1;
    endtask

    task automatic push_exp(input int i, input logic [7:0] r);
        sb.push_back('{idx: i, res: r});
    endtask

    task automatic run_job(input int i, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] r, output int dc);
        seen = '0;
        cyc  = 0;
        set_job(i, a, b);
        push_exp(i, r);
        wait_mask(N'(1 << i), 400);
        dc = last_cyc;
    endtask

    initial begin
        int dc;
        int e;
        req = '0; opa = '0; opb = '0; hold = 1'b0; nrst = 1'b0;
        checks = 0; errors = 0; cyc = 0; starts = 0; last_cyc = 0; seen = '0;
        dc = 0; e = 0;

        tick();
        tick();
        chk("rst_done", 32'(done), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_start", 32'(eng_start), 0);
        chk("rst_gnt", 32'(gnt_idx), 0);
        chk("rst_res", 32'(res), 0);
        chk("rst_ina", 32'(eng_ina), 0);
        chk("rst_inb", 32'(eng_inb), 0);
        nrst = 1'b1;

        // Single request; engine held not-ready first so IDLE must keep waiting.
        hold = 1'b1;
        starts = 0;
        seen = '0;
        set_job(0, 8'd12, 8'd18);
        push_exp(0, 8'd6);
        repeat (3) tick();
        chk("hold_busy", 32'(busy), 0);
        chk("hold_start", starts, 0);
        hold = 1'b0;
        wait_mask(4'b0001, 200);
        chk("t1_busy_at_done", 32'(busy), 1);
        tick();
        chk("t1_busy_after", 32'(busy), 0);
        chk("t1_starts", starts, 1);

        // Equal operands: start at cycle 1, done at cycle 4.
        starts = 0;
        seen = '0;
        cyc = 0;
        set_job(1, 8'd7, 8'd7);
        push_exp(1, 8'd7);
        tick();
        chk("t2_start_c1", 32'(eng_start), 1);
        chk("t2_ina", 32'(eng_ina), 7);
        chk("t2_inb", 32'(eng_inb), 7);
        wait_mask(4'b0010, 50);
        chk("t2_done_cycle", last_cyc, 4);
        chk("t2_starts", starts, 1);
        tick();

        // Zero-operand jobs bypass the engine.
        starts = 0;
        run_job(2, 8'd0, 8'd9, 8'd9, dc);
        chk("t3a_cycle", dc, 1);
        tick();
        run_job(3, 8'd15, 8'd0, 8'd15, dc);
        chk("t3b_cycle", dc, 1);
        tick();
        run_job(0, 8'd0, 8'd0, 8'd0, dc);
        chk("t3c_cycle", dc, 1);
        tick();
        chk("t3_no_start", starts, 0);

        // All four requesters from reset release: served 0,1,2,3.
        nrst = 1'b0;
        set_job(0, 8'd48, 8'd36);
        set_job(1, 8'd35, 8'd14);
        set_job(2, 8'd27, 8'd9);
        set_job(3, 8'd17, 8'd5);
        tick();
        nrst = 1'b1;
        push_exp(0, 8'd12);
        push_exp(1, 8'd7);
        push_exp(2, 8'd9);
        push_exp(3, 8'd1);
        seen = '0;
        wait_mask(4'b1111, 600);
        tick();

        // Fairness between two continuously re-arming requesters.
        set_job(0, 8'd9, 8'd6);
        set_job(2, 8'd10, 8'd4);
        push_exp(0, 8'd3);
        push_exp(2, 8'd2);
        push_exp(0, 8'd3);
        push_exp(2, 8'd2);
        for (int k = 0; k < 4; k++) begin
            e = (k % 2 == 0) ? 0 : 2;
            seen = '0;
            wait_mask(N'(1 << e), 200);
            if (k < 2) req[e] = 1'b1;
        end
        tick();

        // Reset in the middle of a long engine run abandons the job.
        seen = '0;
        cyc = 0;
        set_job(3, 8'd200, 8'd3);
        repeat (5) tick();
        chk("t6_busy_mid", 32'(busy), 1);
        chk("t6_no_done_mid", 32'(done), 0);
        chk("t6_gnt_mid", 32'(gnt_idx), 3);
        nrst = 1'b0;
        req = '0;
        tick();
        nrst = 1'b1;
        chk("t6_rst_done", 32'(done), 0);
        chk("t6_rst_busy", 32'(busy), 0);
        chk("t6_rst_start", 32'(eng_start), 0);
        chk("t6_rst_gnt", 32'(gnt_idx), 0);
        chk("t6_rst_res", 32'(res), 0);
        repeat (2) begin
            tick();
            chk("t6_idle_busy", 32'(busy), 0);
            chk("t6_idle_done", 32'(done), 0);
        end
        // Pointer back at 0: requester 1 must win over requester 3.
        set_job(1, 8'd8, 8'd12);
        set_job(3, 8'd200, 8'd3);
        push_exp(1, 8'd4);
        push_exp(3, 8'd1);
        seen = '0;
        wait_mask(4'b1010, 600);
        tick();
        chk("sb_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
